// File: rtl/leb128_pkg.sv
// rtl/leb128_pkg.sv - shared constants and state type for the LEB128 u32 stream decoder
package leb128_pkg;

  localparam int MAX_BYTES = 5;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OVERRUN  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    EMIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/leb128_u32_stream_if.sv
// rtl/leb128_u32_stream_if.sv - byte-in / value-out stream bundle for the LEB128 decoder
interface leb128_u32_stream_if;

  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [2:0]  out_len;
  logic        out_valid;
  logic        out_ready;
  logic        err;
  logic [1:0]  err_code;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_len, out_valid, err, err_code
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_len, out_valid, err, err_code
  );

endinterface

// File: rtl/leb128_u32_decode.sv
// rtl/leb128_u32_decode.sv - combinational assembly of up to five 7-bit groups into a u32
module leb128_u32_decode
  import leb128_pkg::*;
(
  input  logic [MAX_BYTES-1:0][6:0] i_groups,
  input  logic [2:0]                i_count,
  output logic [31:0]               o_value
);

  // Groups at or beyond i_count are masked; the top group's high bits fall off the 32-bit result
  always_comb begin
    o_value = '0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (3'(k) < i_count) begin
        o_value = o_value | (32'(i_groups[k]) << (7 * k));
      end
    end
  end

endmodule

// File: rtl/leb128_u32_stream.sv
// rtl/leb128_u32_stream.sv - LEB128 unsigned 32-bit stream decoder; LEB128_STATS_EN adds value/error counters
module leb128_u32_stream
  import leb128_pkg::*;
#(
  parameter int STRICT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  leb128_u32_stream_if.slave   bus
`ifdef LEB128_STATS_EN
  ,
  output logic [15:0]          val_cnt,
  output logic [15:0]          err_cnt
`endif
);

  localparam logic [2:0] LAST_IDX = 3'(MAX_BYTES - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [2:0]                r_idx;
  logic [2:0]                w_idx_nxt;
  logic [MAX_BYTES-1:0][6:0] r_buf;
  logic [MAX_BYTES-1:0][6:0] w_groups;
  logic [2:0]                w_count;
  logic [31:0]               w_dec_value;
  logic [31:0]               r_out_data;
  logic [2:0]                r_out_len;
  logic                      r_err;
  logic                      w_err_nxt;
  logic [1:0]                r_err_code;
  logic [1:0]                w_err_code_nxt;
  logic                      w_in_ready;
  logic                      w_accept;
  logic                      w_store;
  logic                      w_load;

  // in_ready is a pure function of state so out_ready never reaches it combinationally
  assign w_in_ready = (r_state != EMIT);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_count    = r_idx + 3'd1;

  // Present the live byte in its slot so a terminator decodes in the same cycle it arrives
  always_comb begin
    for (int k = 0; k < MAX_BYTES; k++) begin
      w_groups[k] = (3'(k) == r_idx) ? bus.in_data[6:0] : r_buf[k];
    end
  end

  leb128_u32_decode u_decode (
    .i_groups (w_groups),
    .i_count  (w_count),
    .o_value  (w_dec_value)
  );

  // Next-state, index and error decisions
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_err_nxt      = 1'b0;
    w_err_code_nxt = ERR_NONE;
    w_store        = 1'b0;
    w_load         = 1'b0;
    case (r_state)
      ACC: begin
        if (w_accept) begin
          w_store = 1'b1;
          if (bus.in_data[7]) begin
            if (r_idx == LAST_IDX) begin
              w_err_nxt      = 1'b1;
              w_err_code_nxt = ERR_OVERRUN;
              w_state_nxt    = DRAIN;
              w_idx_nxt      = 3'd0;
            end else begin
              w_idx_nxt = r_idx + 3'd1;
            end
          end else if ((STRICT != 0) && (r_idx == LAST_IDX) && (bus.in_data[6:4] != 3'b000)) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_OVERFLOW;
            w_idx_nxt      = 3'd0;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = EMIT;
            w_idx_nxt   = 3'd0;
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          w_state_nxt = ACC;
        end
      end
      DRAIN: begin
        if (w_accept && !bus.in_data[7]) begin
          w_state_nxt = ACC;
        end
      end
      default: begin
        w_state_nxt = ACC;
        w_idx_nxt   = 3'd0;
      end
    endcase
  end

  // State and byte index register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACC;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Byte buffer: payload of each accepted byte lands in its slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf <= '0;
    end else if (w_store) begin
      for (int k = 0; k < MAX_BYTES; k++) begin
        if (3'(k) == r_idx) begin
          r_buf[k] <= bus.in_data[6:0];
        end
      end
    end
  end

  // Output register, captured on the terminating byte and held through EMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data <= 32'd0;
      r_out_len  <= 3'd0;
    end else if (w_load) begin
      r_out_data <= w_dec_value;
      r_out_len  <= w_count;
    end
  end

  // Error pulse: one cycle wide, code cleared alongside it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_err      <= w_err_nxt;
      r_err_code <= w_err_code_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == EMIT);
  assign bus.out_data  = r_out_data;
  assign bus.out_len   = r_out_len;
  assign bus.err       = r_err;
  assign bus.err_code  = r_err_code;

`ifdef LEB128_STATS_EN
  logic [15:0] r_val_cnt;
  logic [15:0] r_err_cnt;

  // Saturating counters of delivered values and error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val_cnt <= 16'd0;
      r_err_cnt <= 16'd0;
    end else begin
      if (bus.out_ready && (r_state == EMIT) && (r_val_cnt != 16'hFFFF)) begin
        r_val_cnt <= r_val_cnt + 16'd1;
      end
      if (r_err && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign val_cnt = r_val_cnt;
  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_leb128_u32_stream.sv
// tb/tb_leb128_u32_stream.sv - directed and random stimulus for leb128_u32_stream (optionally LEB128_STATS_EN)
`define CHK(TAG, OBS, EXP) begin checks++; assert ((OBS) === (EXP)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", TAG, (OBS), (EXP)); end end

module tb_leb128_u32_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  leb128_u32_stream_if bus();

`ifdef LEB128_STATS_EN
  logic [15:0] val_cnt;
  logic [15:0] err_cnt;
`endif

  leb128_u32_stream #(.STRICT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef LEB128_STATS_EN
    ,
    .val_cnt (val_cnt),
    .err_cnt (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state: running value as a wide integer
  logic [63:0] m_val;
  int          m_cnt;
  bit          m_drain;
  int          exp_vals;
  int          exp_errs;

  task automatic model_reset();
    m_val    = 64'd0;
    m_cnt    = 0;
    m_drain  = 1'b0;
    exp_vals = 0;
    exp_errs = 0;
  endtask

  // kind: 0 nothing, 1 value produced, 2 error pulse
  task automatic model_step(input logic [7:0] b, output int kind, output logic [31:0] v,
                            output logic [2:0] len, output logic [1:0] code);
    kind = 0;
    v    = 32'd0;
    len  = 3'd0;
    code = 2'b00;
    if (m_drain) begin
      if (!b[7]) m_drain = 1'b0;
      return;
    end
    m_val = m_val + (64'(b[6:0]) << (7 * m_cnt));
    m_cnt++;
    if (!b[7]) begin
      if (m_val > 64'h0000_0000_FFFF_FFFF) begin
        kind = 2;
        code = 2'b10;
      end else begin
        kind = 1;
        v    = m_val[31:0];
        len  = 3'(m_cnt);
      end
      m_val = 64'd0;
      m_cnt = 0;
    end else if (m_cnt == 5) begin
      kind    = 2;
      code    = 2'b01;
      m_drain = 1'b1;
      m_val   = 64'd0;
      m_cnt   = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int          kind;
    logic [31:0] v;
    logic [2:0]  len;
    logic [1:0]  code;
    int          waited;
    model_step(b, kind, v, len, code);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    `CHK("in_ready_before_byte", bus.in_ready, 1'b1)
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    `CHK("err", bus.err, (kind == 2))
    `CHK("err_code", bus.err_code, code)
    `CHK("out_valid", bus.out_valid, (kind == 1))
    if (kind == 1) begin
      `CHK("out_data", bus.out_data, v)
      `CHK("out_len", bus.out_len, len)
      `CHK("in_ready_emit", bus.in_ready, 1'b0)
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        `CHK("stall_out_valid", bus.out_valid, 1'b1)
        `CHK("stall_out_data", bus.out_data, v)
        `CHK("stall_out_len", bus.out_len, len)
        `CHK("stall_in_ready", bus.in_ready, 1'b0)
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      exp_vals++;
      `CHK("out_valid_after_xfer", bus.out_valid, 1'b0)
      `CHK("in_ready_after_xfer", bus.in_ready, 1'b1)
    end else if (kind == 2) begin
      exp_errs++;
      @(posedge clk); #1;
      `CHK("err_pulse_end", bus.err, 1'b0)
      `CHK("err_code_clear", bus.err_code, 2'b00)
    end
  endtask

  task automatic check_reset_state();
    `CHK("rst_out_valid", bus.out_valid, 1'b0)
    `CHK("rst_out_data", bus.out_data, 32'd0)
    `CHK("rst_out_len", bus.out_len, 3'd0)
    `CHK("rst_err", bus.err, 1'b0)
    `CHK("rst_err_code", bus.err_code, 2'b00)
    `CHK("rst_in_ready", bus.in_ready, 1'b1)
`ifdef LEB128_STATS_EN
    `CHK("rst_val_cnt", val_cnt, 16'd0)
    `CHK("rst_err_cnt", err_cnt, 16'd0)
`endif
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check_reset_state();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [7:0] rb;
    bus.in_data   = 8'd0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;

    // Single-byte value
    send_byte(8'h05, 0);
    // Three-byte value 624485
    send_byte(8'hE5, 0); send_byte(8'h8E, 0); send_byte(8'h26, 0);
    // Largest legal value, then a 5th byte that exceeds 32 bits
    send_byte(8'hFF, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0); send_byte(8'h0F, 0);
    send_byte(8'hFF, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0); send_byte(8'h1F, 0);
    // Overrun, drain, then recovery
    for (int i = 0; i < 5; i++) send_byte(8'h80, 0);
    send_byte(8'h81, 0); send_byte(8'h01, 0); send_byte(8'h07, 0);
    // Back-pressure on the output
    send_byte(8'hE5, 0); send_byte(8'h8E, 0); send_byte(8'h26, 3);
    // Reset in the middle of a value
    send_byte(8'hE5, 0); send_byte(8'h8E, 0);
    do_reset();
    send_byte(8'h05, 0);
    // Reset while draining
    for (int i = 0; i < 5; i++) send_byte(8'h80, 0);
    send_byte(8'h85, 0);
    do_reset();
    send_byte(8'h2A, 1);

    // Random byte stream with idles, stalls and occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rb = {1'b0, 7'($urandom)};
      else                           rb = {1'b1, 7'($urandom)};
      if ($urandom_range(0, 5) == 0) rb = {1'b0, 7'($urandom_range(0, 31))};
      send_byte(rb, int'($urandom_range(0, 2)));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    repeat (2) @(posedge clk);
    #1;
`ifdef LEB128_STATS_EN
    `CHK("val_cnt", val_cnt, 16'(exp_vals))
    `CHK("err_cnt", err_cnt, 16'(exp_errs))
`endif
    `CHK("idle_out_valid", bus.out_valid, 1'b0)
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
